// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: receiver handshake, FIFO output stream and status bundle for uart_rx_ctrl
interface uart_rx_ctrl_if #(
    parameter int CW = 5
);
    logic [7:0]    rx_data;
    logic          rx_sent;
    logic [3:0]    rx_error;
    logic          rx_ack;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [7:0]    err_count;
    logic          clear;
    modport master (
        output rx_data, rx_sent, rx_error, out_ready, clear,
        input  rx_ack, out_data, out_valid, fifo_count, overflow, err_count
    );
    modport slave (
        input  rx_data, rx_sent, rx_error, out_ready, clear,
        output rx_ack, out_data, out_valid, fifo_count, overflow, err_count
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: acknowledges receiver bytes into a first-word-fall-through FIFO,
// tracking sticky overflow and a saturating receiver error count.
module uart_rx_ctrl #(
    parameter int DEPTH = 4,
    parameter int CW    = 5
) (
    input logic           clk,
    input logic           rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, WAIT_CLR = 2'd2} state_t;
    state_t        state, state_nx;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [3:0]    prev_err;
    logic [7:0]    err_count;
    logic          rx_ack, overflow;
    logic          capture, pop, accept, err_evt;
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:     state_nx = bus.rx_sent ? ACK : IDLE;
            ACK:      state_nx = WAIT_CLR;
            WAIT_CLR: state_nx = bus.rx_sent ? WAIT_CLR : IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    assign capture = state == IDLE && bus.rx_sent;
    assign pop     = count != '0 && bus.out_ready;
    // A full FIFO still takes the byte when the head leaves in the same cycle
    assign accept  = capture && (count < FULL || pop);
    assign err_evt = prev_err == '0 && bus.rx_error != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rx_ack    <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            prev_err  <= '0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            rx_ack    <= state_nx == ACK;
            prev_err  <= bus.rx_error;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count     <= count + CW'(accept) - CW'(pop);
            overflow  <= !bus.clear && (overflow || (capture && !accept));
            err_count <= bus.clear ? '0 : err_count + 8'(err_evt && err_count != 8'hFF);
        end
    end
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= bus.rx_data;
    end
    assign bus.rx_ack     = rx_ack;
    assign bus.out_data   = mem[rd_ptr];
    assign bus.out_valid  = count != '0;
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow;
    assign bus.err_count  = err_count;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed vector table for FIFO fill/drain plus hand sequences
// for simultaneous push/pop, error counting, held rx_sent and mid-handshake reset.
module tb_uart_rx_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    uart_rx_ctrl_if #(.CW(5)) bus ();
    uart_rx_ctrl #(.DEPTH(4), .CW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        bit         is_pop;
        logic [7:0] data;
        int         exp_count;
        logic [7:0] exp_head;
        bit         exp_ovf;
    } vec_t;
    vec_t vecs [11];
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data = b;
        bus.rx_sent = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rx_ack && n < 10);
        chk("ack_latency", n, 1);
        bus.rx_sent = 1'b0;
        @(negedge clk);
        chk("ack_pulse", int'(bus.rx_ack), 0);
        @(negedge clk);
    endtask
    task automatic pop_one();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask
    task automatic pop_check(input string name, input logic [7:0] exp);
        chk(name, int'(bus.out_data), int'(exp));
        pop_one();
    endtask
    initial begin
        vecs = '{
            '{1'b0, 8'hA5, 1, 8'hA5, 1'b0},
            '{1'b1, 8'h00, 0, 8'h00, 1'b0},
            '{1'b0, 8'h01, 1, 8'h01, 1'b0},
            '{1'b0, 8'h02, 2, 8'h01, 1'b0},
            '{1'b0, 8'h03, 3, 8'h01, 1'b0},
            '{1'b0, 8'h04, 4, 8'h01, 1'b0},
            '{1'b0, 8'h05, 4, 8'h01, 1'b1},
            '{1'b1, 8'h00, 3, 8'h02, 1'b1},
            '{1'b1, 8'h00, 2, 8'h03, 1'b1},
            '{1'b1, 8'h00, 1, 8'h04, 1'b1},
            '{1'b1, 8'h00, 0, 8'h00, 1'b1}
        };
        rst = 1'b1;
        bus.rx_data = '0;
        bus.rx_sent = 1'b0;
        bus.rx_error = '0;
        bus.out_ready = 1'b0;
        bus.clear = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_count", int'(bus.fifo_count), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_ack", int'(bus.rx_ack), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_err", int'(bus.err_count), 0);
        rst = 1'b0;
        bus.clear = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_pop) pop_one();
            else send_byte(vecs[i].data);
            chk($sformatf("v%0d_count", i), int'(bus.fifo_count), vecs[i].exp_count);
            chk($sformatf("v%0d_valid", i), int'(bus.out_valid), int'(vecs[i].exp_count != 0));
            if (vecs[i].exp_count != 0)
                chk($sformatf("v%0d_head", i), int'(bus.out_data), int'(vecs[i].exp_head));
            chk($sformatf("v%0d_ovf", i), int'(bus.overflow), int'(vecs[i].exp_ovf));
        end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clear_ovf", int'(bus.overflow), 0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("full_count", int'(bus.fifo_count), 4);
        bus.rx_data = 8'h66;
        bus.rx_sent = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.rx_sent = 1'b0;
        chk("fullpop_ack", int'(bus.rx_ack), 1);
        chk("fullpop_count", int'(bus.fifo_count), 4);
        chk("fullpop_ovf", int'(bus.overflow), 0);
        repeat (2) @(negedge clk);
        pop_check("fp_head0", 8'h22);
        pop_check("fp_head1", 8'h33);
        pop_check("fp_head2", 8'h44);
        pop_check("fp_head3", 8'h66);
        chk("fp_empty", int'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("empty_pop_count", int'(bus.fifo_count), 0);
        bus.rx_error = 4'd1;
        repeat (3) @(negedge clk);
        bus.rx_error = 4'd3;
        repeat (3) @(negedge clk);
        bus.rx_error = 4'd0;
        repeat (3) @(negedge clk);
        bus.rx_error = 4'd2;
        repeat (3) @(negedge clk);
        bus.rx_error = 4'd0;
        @(negedge clk);
        chk("err_two", int'(bus.err_count), 2);
        for (int k = 0; k < 300; k++) begin
            bus.rx_error = 4'd5;
            @(negedge clk);
            bus.rx_error = 4'd0;
            @(negedge clk);
        end
        chk("err_sat", int'(bus.err_count), 255);
        bus.rx_error = 4'd1;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.rx_error = 4'd0;
        chk("err_clear", int'(bus.err_count), 0);
        @(negedge clk);
        bus.rx_error = 4'd4;
        @(negedge clk);
        bus.rx_error = 4'd0;
        chk("err_after_clear", int'(bus.err_count), 1);
        bus.rx_data = 8'h77;
        bus.rx_sent = 1'b1;
        @(negedge clk);
        chk("hold_ack", int'(bus.rx_ack), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_count", k), int'(bus.fifo_count), 1);
            chk($sformatf("hold%0d_ack", k), int'(bus.rx_ack), 0);
        end
        bus.rx_sent = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h78);
        chk("hold_count", int'(bus.fifo_count), 2);
        pop_check("hold_head0", 8'h77);
        pop_check("hold_head1", 8'h78);
        send_byte(8'h31);
        send_byte(8'h32);
        bus.rx_data = 8'h99;
        bus.rx_sent = 1'b1;
        @(negedge clk);
        chk("mid_ack", int'(bus.rx_ack), 1);
        chk("mid_count", int'(bus.fifo_count), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_count", int'(bus.fifo_count), 0);
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_ack", int'(bus.rx_ack), 0);
        @(negedge clk);
        chk("recap_ack", int'(bus.rx_ack), 1);
        chk("recap_count", int'(bus.fifo_count), 1);
        chk("recap_head", int'(bus.out_data), 8'h99);
        repeat (3) @(negedge clk);
        chk("recap_once", int'(bus.fifo_count), 1);
        bus.rx_sent = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
